// File: rtl/range_sched_if.sv
// Range offer channel between a producer and range_sched.
// Transfer occurs on a clock edge where range_valid and range_ready are both high.
interface range_sched_if #(
   parameter int DATA_W = 64
);
   logic              range_valid;
   logic              range_ready;
   logic [DATA_W-1:0] range_lo;
   logic [DATA_W-1:0] range_hi;
   logic              range_last;

   modport master (
      output range_valid,
      output range_lo,
      output range_hi,
      output range_last,
      input  range_ready
   );

   modport slave (
      input  range_valid,
      input  range_lo,
      input  range_hi,
      input  range_last,
      output range_ready
   );
endinterface

// File: rtl/range_sched.sv
// Sequences count_combs over [lo, hi] as S(hi) - S(lo-1).
// The per-range differences are summed into a batch total.
module range_sched #(
   parameter int DATA_W  = 64,
   parameter int SUM_W   = 64,
   parameter int TIMEOUT = 4096
) (
   input  logic              clock,
   input  logic              reset_n,
   range_sched_if.slave      rng,
   output logic [DATA_W-1:0] cc_n,
   output logic              cc_reset,
   input  logic [SUM_W-1:0]  cc_count,
   input  logic              cc_valid,
   output logic [SUM_W-1:0]  total,
   output logic              total_valid,
   output logic              busy,
   output logic              err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE, RST_HI, RUN_HI, RST_LO, RUN_LO, ACC, DONE
   } st_t;

   st_t st, st_nxt;

   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] lo_q;
   logic              last_q;
   logic [SUM_W-1:0]  hi_cnt;
   logic [SUM_W-1:0]  lo_cnt;
   logic              rdy_en;
   logic              park;
   logic              run;
   logic              accept;
   logic              bad;
   logic              tmo;
   st_t               fin;

   assign park = (st == IDLE) || (st == DONE);
   assign run  = (st == RUN_HI) || (st == RUN_LO);

   // rdy_en keeps ready low until the first edge after reset release
   assign rng.range_ready = rdy_en & park;
   assign accept = rng.range_valid & rng.range_ready;
   assign bad    = rng.range_lo > rng.range_hi;
   assign tmo    = run & ~cc_valid & (cnt == T_LAST);
   assign fin    = last_q ? DONE : IDLE;

   assign cc_reset    = ~run;
   assign busy        = ~park;
   assign total_valid = (st == DONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) st <= IDLE;
      else          st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      unique case (st)
         IDLE, DONE: begin
            if (accept) begin
               if (bad) st_nxt = rng.range_last ? DONE : IDLE;
               else     st_nxt = RST_HI;
            end
         end
         RST_HI: if (cnt == C_ONE) st_nxt = RUN_HI;
         RUN_HI: begin
            if (cc_valid)  st_nxt = (lo_q == '0) ? ACC : RST_LO;
            else if (tmo)  st_nxt = fin;
         end
         RST_LO: if (cnt == C_ONE) st_nxt = RUN_LO;
         RUN_LO: begin
            if (cc_valid)  st_nxt = ACC;
            else if (tmo)  st_nxt = fin;
         end
         ACC:     st_nxt = fin;
         default: st_nxt = IDLE;
      endcase
   end

   // Counts cycles within a reset or run phase
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)           cnt <= '0;
      else if (st_nxt != st)  cnt <= '0;
      else if (!park)         cnt <= cnt + C_ONE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdy_en <= 1'b0;
         cc_n   <= '0;
         lo_q   <= '0;
         last_q <= 1'b0;
         hi_cnt <= '0;
         lo_cnt <= '0;
         total  <= '0;
         err    <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (accept) begin
            lo_q   <= rng.range_lo;
            last_q <= rng.range_last;
            if (st == DONE) total <= '0;
            if (bad) err  <= 1'b1;
            else     cc_n <= rng.range_hi;
         end
         if (st == RUN_HI && cc_valid) begin
            hi_cnt <= cc_count;
            if (lo_q == '0) lo_cnt <= '0;
            else            cc_n   <= lo_q - DATA_W'(1);
         end
         if (st == RUN_LO && cc_valid) lo_cnt <= cc_count;
         if (tmo) err <= 1'b1;
         if (st == ACC) total <= total + hi_cnt - lo_cnt;
      end
   end

endmodule
